// File: rtl/counter_sweep_sequencer.sv
// Sweep sequencer for an external up/down counter: load a floor, count to a ceiling,
// then reload (sawtooth) or count back down (triangle) for a programmed number of sweeps.
module counter_sweep_sequencer #(
  parameter int unsigned N  = 32,
  parameter int unsigned SW = 8
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  input  logic          i_abort,
  input  logic          i_triangle,
  input  logic [N-1:0]  i_start_value,
  input  logic [N-1:0]  i_limit,
  input  logic [SW-1:0] i_sweeps,
  input  logic [N-1:0]  i_counter_value,
  input  logic          i_counter_thr,
  output logic          o_ctr_enable,
  output logic          o_ctr_dec,
  output logic          o_ctr_load,
  output logic [N-1:0]  o_ctr_ref,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_error,
  output logic [SW-1:0] o_sweep_cnt
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_UP   = 3'd2,
    S_DOWN = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic          r_triangle;
  logic [N-1:0]  r_start;
  logic [N-1:0]  r_lim;
  logic [SW-1:0] r_sweeps;
  logic [SW-1:0] r_sweep_cnt;
  logic          r_error;

  logic          w_accept;
  logic          w_cfg_bad;
  logic          w_sweep_inc;
  logic          w_overrun;
  logic [SW-1:0] w_cnt_inc;
  logic          w_last_sweep;

  assign w_cnt_inc    = r_sweep_cnt + SW'(1);
  assign w_last_sweep = (r_sweeps != '0) && (w_cnt_inc == r_sweeps);

  // State register, latched configuration and status
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_triangle  <= 1'b0;
      r_start     <= '0;
      r_lim       <= '0;
      r_sweeps    <= '0;
      r_sweep_cnt <= '0;
      r_error     <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_triangle  <= i_triangle;
        r_start     <= i_start_value;
        r_lim       <= i_limit;
        r_sweeps    <= i_sweeps;
        r_sweep_cnt <= '0;
        r_error     <= w_cfg_bad;
      end else begin
        if (w_sweep_inc) r_sweep_cnt <= w_cnt_inc;
        if (w_overrun)   r_error     <= 1'b1;
      end
    end
  end

  // Next-state logic and counter control decode
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_cfg_bad    = 1'b0;
    w_sweep_inc  = 1'b0;
    w_overrun    = 1'b0;
    o_ctr_enable = 1'b0;
    o_ctr_dec    = 1'b0;
    o_ctr_load   = 1'b0;
    o_ctr_ref    = r_lim;
    o_busy       = (r_state != S_IDLE);
    o_done       = (r_state == S_DONE);

    case (r_state)
      S_LOAD: begin
        o_ctr_load = 1'b1;
        o_ctr_ref  = r_start;
      end
      S_UP: begin
        o_ctr_enable = (i_counter_value != r_lim);
      end
      S_DOWN: begin
        o_ctr_dec    = 1'b1;
        o_ctr_ref    = r_start;
        o_ctr_enable = (i_counter_value != r_start);
      end
      default: ;
    endcase

    if (r_state == S_IDLE) begin
      if (i_start && !i_abort) begin
        w_accept = 1'b1;
        if (i_limit <= i_start_value) w_cfg_bad = 1'b1;
        else                          w_next_state = S_LOAD;
      end
    end else if (i_abort) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_LOAD: w_next_state = S_UP;
        S_UP: begin
          if (i_counter_thr) begin
            w_overrun    = 1'b1;
            w_next_state = S_IDLE;
          end else if (i_counter_value == r_lim) begin
            if (r_triangle) begin
              w_next_state = S_DOWN;
            end else begin
              w_sweep_inc  = 1'b1;
              w_next_state = w_last_sweep ? S_DONE : S_LOAD;
            end
          end
        end
        S_DOWN: begin
          if (i_counter_value == r_start) begin
            w_sweep_inc  = 1'b1;
            w_next_state = w_last_sweep ? S_DONE : S_UP;
          end
        end
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  assign o_error     = r_error;
  assign o_sweep_cnt = r_sweep_cnt;

endmodule
